// File: rtl/memory_access_unit.sv
// memory_access_unit
// Takes the multicycle control unit's level-held load/store requests and turns
// each one into a single-beat AXI4 transaction toward the DCCM. Load data is
// held in a register so the control unit can write it back at its own pace.
// All AXI outputs come straight from flops, so no AXI input reaches an AXI
// output combinationally.

module memory_access_unit #(
  parameter int unsigned             AXI_ID_WIDTH = 4,
  parameter logic [AXI_ID_WIDTH-1:0] AXI_ID       = '0
) (
  input  logic                    clk,
  input  logic                    reset_n,

  // control unit side
  input  logic                    memory_read_enable,
  input  logic                    memory_write_enable,
  input  logic [31:0]             memory_address,
  input  logic [31:0]             memory_write_data,
  output logic [31:0]             memory_read_data,
  output logic                    memory_read_data_valid,
  output logic                    memory_write_done,
  output logic                    memory_error,

  // AXI read address channel
  output logic [31:0]             m_axi_araddr,
  output logic [AXI_ID_WIDTH-1:0] m_axi_arid,
  output logic [7:0]              m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,

  // AXI read data channel
  input  logic [31:0]             m_axi_rdata,
  input  logic [AXI_ID_WIDTH-1:0] m_axi_rid,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rlast,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready,

  // AXI write address channel
  output logic [31:0]             m_axi_awaddr,
  output logic [AXI_ID_WIDTH-1:0] m_axi_awid,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,

  // AXI write data channel
  output logic [31:0]             m_axi_wdata,
  output logic [3:0]              m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,

  // AXI write response channel
  input  logic [AXI_ID_WIDTH-1:0] m_axi_bid,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR,
    WR_RESP,
    COMPLETE
  } state_t;

  state_t state;

  // A word access whose address is not 4-byte aligned is rejected locally.
  logic misaligned;
  assign misaligned = |memory_address[1:0];

  // Every transaction is a single full-word INCR beat with a fixed ID.
  assign m_axi_arid    = AXI_ID;
  assign m_axi_arlen   = 8'd0;
  assign m_axi_arsize  = 3'b010;
  assign m_axi_arburst = 2'b01;
  assign m_axi_awid    = AXI_ID;
  assign m_axi_awlen   = 8'd0;
  assign m_axi_awsize  = 3'b010;
  assign m_axi_awburst = 2'b01;
  assign m_axi_wstrb   = 4'hF;
  assign m_axi_wlast   = m_axi_wvalid;

  // Response IDs and rlast carry nothing useful for single-beat, single-ID traffic.
  logic unused_axi_inputs;
  assign unused_axi_inputs = ^{m_axi_rid, m_axi_rlast, m_axi_bid};

  // Request FSM: accepts one request, runs its AXI transaction, pulses
  // completion, then waits for the control unit to drop its enables.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state                  <= IDLE;
      memory_read_data       <= 32'd0;
      memory_read_data_valid <= 1'b0;
      memory_write_done      <= 1'b0;
      memory_error           <= 1'b0;
      m_axi_araddr           <= 32'd0;
      m_axi_arvalid          <= 1'b0;
      m_axi_rready           <= 1'b0;
      m_axi_awaddr           <= 32'd0;
      m_axi_awvalid          <= 1'b0;
      m_axi_wdata            <= 32'd0;
      m_axi_wvalid           <= 1'b0;
      m_axi_bready           <= 1'b0;
    end else begin
      // completion indications are single-cycle pulses
      memory_read_data_valid <= 1'b0;
      memory_write_done      <= 1'b0;

      case (state)
        IDLE: begin
          if (memory_read_enable) begin
            memory_error <= misaligned;
            if (misaligned) begin
              memory_read_data_valid <= 1'b1;
              state                  <= COMPLETE;
            end else begin
              m_axi_araddr  <= memory_address;
              m_axi_arvalid <= 1'b1;
              state         <= RD_ADDR;
            end
          end else if (memory_write_enable) begin
            memory_error <= misaligned;
            if (misaligned) begin
              memory_write_done <= 1'b1;
              state             <= COMPLETE;
            end else begin
              m_axi_awaddr  <= memory_address;
              m_axi_wdata   <= memory_write_data;
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
              state         <= WR;
            end
          end
        end

        RD_ADDR: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= RD_DATA;
          end
        end

        RD_DATA: begin
          if (m_axi_rvalid) begin
            memory_read_data       <= m_axi_rdata;
            memory_error           <= (m_axi_rresp != 2'b00);
            m_axi_rready           <= 1'b0;
            memory_read_data_valid <= 1'b1;
            state                  <= COMPLETE;
          end
        end

        WR: begin
          // AW and W complete independently; leave once neither is outstanding
          if (m_axi_awvalid && m_axi_awready) begin
            m_axi_awvalid <= 1'b0;
          end
          if (m_axi_wvalid && m_axi_wready) begin
            m_axi_wvalid <= 1'b0;
          end
          if ((!m_axi_awvalid || m_axi_awready) && (!m_axi_wvalid || m_axi_wready)) begin
            m_axi_bready <= 1'b1;
            state        <= WR_RESP;
          end
        end

        WR_RESP: begin
          if (m_axi_bvalid) begin
            m_axi_bready      <= 1'b0;
            memory_error      <= (m_axi_bresp != 2'b00);
            memory_write_done <= 1'b1;
            state             <= COMPLETE;
          end
        end

        COMPLETE: begin
          // the control unit may still hold its enable the cycle it sees the pulse
          if (!memory_read_enable && !memory_write_enable) begin
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/memory_access_unit.md
Name: memory_access_unit

Overview:
- Responder on the control unit's memory handshake (memory_read_enable / memory_write_enable in; memory_read_data_valid / memory_write_done out).
- Converts each request into one single-beat AXI4 master transaction toward the DCCM data memory.
- Holds load data stable for the control unit's write-back.
- Sits between the multicycle control unit and the DCCM AXI slave port.

Parameters:
- AXI_ID_WIDTH, 4, width of arid/awid/rid/bid.
- AXI_ID, 0, fixed transaction ID driven on arid/awid.

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- memory_read_enable  in  1  load request, level, held until memory_read_data_valid
- memory_write_enable  in  1  store request, level, held until memory_write_done
- memory_address  in  32  byte address, valid while an enable is high
- memory_write_data  in  32  store data, valid while memory_write_enable is high
- memory_read_data  out  32  registered load data
- memory_read_data_valid  out  1  one-cycle pulse, load complete
- memory_write_done  out  1  one-cycle pulse, store complete
- memory_error  out  1  last access misaligned or got a non-OKAY response
- m_axi_araddr  out  32; m_axi_arid  out  AXI_ID_WIDTH; m_axi_arlen  out  8; m_axi_arsize  out  3; m_axi_arburst  out  2; m_axi_arvalid  out  1; m_axi_arready  in  1
- m_axi_rdata  in  32; m_axi_rid  in  AXI_ID_WIDTH; m_axi_rresp  in  2; m_axi_rlast  in  1; m_axi_rvalid  in  1; m_axi_rready  out  1
- m_axi_awaddr  out  32; m_axi_awid  out  AXI_ID_WIDTH; m_axi_awlen  out  8; m_axi_awsize  out  3; m_axi_awburst  out  2; m_axi_awvalid  out  1; m_axi_awready  in  1
- m_axi_wdata  out  32; m_axi_wstrb  out  4; m_axi_wlast  out  1; m_axi_wvalid  out  1; m_axi_wready  in  1
- m_axi_bid  in  AXI_ID_WIDTH; m_axi_bresp  in  2; m_axi_bvalid  in  1; m_axi_bready  out  1

Behaviour:
- One clock (clk); reset_n is asynchronous, active-low.
- Reset values: all valid/ready/done/error outputs 0, memory_read_data 0, address/data registers 0, state IDLE.
- Constant outputs: arid/awid = AXI_ID, arlen/awlen = 0, arsize/awsize = 3'b010, arburst/awburst = 2'b01, wstrb = 4'hF, wlast = 1 (the same cycles as wvalid).
- All AXI outputs are driven from registers; no combinational path from AXI inputs to AXI outputs.

States:
- IDLE:
  - On read_enable, latch address and go to RD_ADDR with arvalid = 1. Read has priority if both enables are high.
  - Otherwise, on write_enable, latch address and data and go to WR with awvalid = 1 and wvalid = 1.
  - Latching a new request clears memory_error.
  - If memory_address[1:0] != 0, issue no AXI traffic: set memory_error, pulse the matching done/valid next cycle, go to COMPLETE. memory_read_data is unchanged.
- RD_ADDR: hold arvalid and araddr stable until arready. On that handshake, drop arvalid, raise rready, go to RD_DATA.
- RD_DATA: on rvalid & rready:
  - capture rdata into memory_read_data; set memory_error if rresp != 2'b00;
  - drop rready; pulse memory_read_data_valid for exactly one cycle; go to COMPLETE.
  - rid and rlast are ignored.
- WR:
  - AW and W are tracked independently; each valid drops on its own handshake, in either order or in the same cycle.
  - Once both handshakes are done, raise bready and go to WR_RESP.
- WR_RESP: on bvalid & bready, drop bready, set memory_error if bresp != 0, pulse memory_write_done for one cycle, go to COMPLETE.
- COMPLETE:
  - Wait until both enables are low, then return to IDLE.
  - This prevents re-issuing a request on the cycle the control unit is still holding its enable.
- Latency:
  - Read: valid pulse on the clock edge after the R handshake. Minimum 3 cycles from enable with zero-wait slave.
  - Write: minimum 3 cycles from enable.
- Data retention: memory_read_data holds until the next successful or errored read capture. Writes and misaligned accesses leave it unchanged.
- Enable deassert mid-transaction (protocol violation):
  - An in-flight AXI transaction still completes and its done/valid still pulses.
  - No new request is accepted before COMPLETE → IDLE.
- Reset mid-transaction: immediate return to IDLE with all valids low. The DCCM shares reset_n, so no outstanding-transaction recovery is needed.

Test Plan:
- Read, zero-wait slave, addr 0x0000_0010, rdata 0xDEADBEEF, rresp OKAY:
  - → araddr 0x10; single valid pulse; memory_read_data = 0xDEADBEEF held afterwards; memory_error 0.
- Write, addr 0x20, data 0x1234_5678:
  - awready 2 cycles before wready → one AW handshake and one W handshake with wstrb F and wlast 1; bready raised only after both; single done pulse after bvalid.
- Misaligned read at 0x0000_0013 → no arvalid ever; memory_read_data_valid pulses; memory_error 1; memory_read_data keeps its previous value.
- Error responses:
  - Read with rresp = 2'b10 → valid pulses, memory_error 1.
  - Next aligned OKAY write → memory_error clears on accept, done pulses.
- Control unit holds enable 1 cycle after the done pulse, then re-raises it for a new request → exactly one AXI transaction per request; no duplicate arvalid.
- Assert reset_n low while arvalid is stalled (arready = 0) → arvalid drops asynchronously; after release, state is IDLE and all outputs are 0.
